// File: rtl/vga_timing_pkg.sv
// Shared types, video-mode presets and helpers for the VGA timing generator.
//   coord_t        : coordinate type at the default 10-bit width
//   axis_timing_t  : active/front-porch/sync/back-porch group for one axis
//   video_mode_t   : pixel-clock divider plus horizontal and vertical groups
//   total()        : sum of the four segments of an axis
package vga_timing_pkg;

  localparam int unsigned CW_DEFAULT = 10;

  typedef logic [CW_DEFAULT-1:0] coord_t;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  typedef struct packed {
    int unsigned  clk_div;
    axis_timing_t h;
    axis_timing_t v;
  } video_mode_t;

  // 25 MHz pixel clock from a 50 MHz system clock.
  localparam video_mode_t MODE_640x480_60 = '{
    clk_div: 2,
    h: '{active: 640, fp: 16, sync: 96, bp: 48},
    v: '{active: 480, fp: 10, sync: 2,  bp: 33}
  };

  // 50 MHz pixel clock, so the system clock is used directly.
  localparam video_mode_t MODE_800x600_72 = '{
    clk_div: 1,
    h: '{active: 800, fp: 56, sync: 120, bp: 64},
    v: '{active: 600, fp: 37, sync: 6,   bp: 23}
  };

  function automatic int unsigned total(input int unsigned active,
                                        input int unsigned fp,
                                        input int unsigned sync,
                                        input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA raster.
//   Clk         : system clock
//   Reset       : synchronous clear (active-high), forces count to 0
//   step        : advance the count by one this cycle
//   count       : registered position on the axis
//   next_count  : value count takes at the coming edge
//   wrap        : this cycle's step moves count from TOTAL-1 back to 0
//   sync_active : next_count lies in the sync segment (polarity-free)
//   sync_level  : sync_active driven to the POL polarity
//   visible     : next_count lies in the active segment
// The decodes describe next_count so the parent can register them on the
// same edge as count and keep position and sync/blank skew-free.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic [CW-1:0] next_count,
  output logic          wrap,
  output logic          sync_active,
  output logic          sync_level,
  output logic          visible
);

  localparam int unsigned   TOTAL      = total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  // One extra bit so segment ends equal to 2^CW still compare correctly.
  localparam logic [CW:0]   ACTIVE_END = (CW+1)'(ACTIVE);
  localparam logic [CW:0]   SYNC_START = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0]   SYNC_END   = (CW+1)'(ACTIVE + FP + SYNC);

  if (longint'(TOTAL) > (longint'(1) << CW)) begin : g_total_check
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CW);
  end

  logic [CW:0] next_ext;

  // NOTE: the default assignment comes first so every path through the block
  // drives next_count; a missing branch would otherwise infer a latch.
  always_comb begin
    next_count = count;
    if (Reset) begin
      next_count = '0;
    end else if (step) begin
      next_count = (count == LAST) ? '0 : count + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge Clk) begin
    if (Reset) count <= '0;
    else       count <= next_count;
  end

  assign wrap        = ~Reset & step & (count == LAST);
  assign next_ext    = {1'b0, next_count};
  assign visible     = next_ext < ACTIVE_END;
  assign sync_active = ~Reset & (next_ext >= SYNC_START) & (next_ext < SYNC_END);
  assign sync_level  = sync_active ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
//   Clk          : system clock
//   Reset        : synchronous, active-high; has priority over Enable
//   Enable       : 1 = run, 0 = hold everything in the reset state
//   pixel_ce     : one-Clk pulse per pixel period (from registered state)
//   hs, vs       : syncs with HS_POL / VS_POL polarity
//   blank        : 1 on visible pixels while running
//   sync         : composite sync, low while hs or vs is asserted
//   DrawX, DrawY : raw raster position
//   PlayX, PlayY : (Draw + offset) mod 2^CW, shifted right by SCALE_LOG2
//   line_start   : strobe on every DrawX wrap
//   frame_start  : strobe on the wrap to (0,0)
//   vblank_start : strobe when DrawY steps from V_ACTIVE-1 to V_ACTIVE
// Every output except pixel_ce is registered from next-state counts, so it
// changes on the same edge as DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = MODE_640x480_60.clk_div,
  parameter int unsigned H_ACTIVE   = MODE_640x480_60.h.active,
  parameter int unsigned H_FP       = MODE_640x480_60.h.fp,
  parameter int unsigned H_SYNC     = MODE_640x480_60.h.sync,
  parameter int unsigned H_BP       = MODE_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE   = MODE_640x480_60.v.active,
  parameter int unsigned V_FP       = MODE_640x480_60.v.fp,
  parameter int unsigned V_SYNC     = MODE_640x480_60.v.sync,
  parameter int unsigned V_BP       = MODE_640x480_60.v.bp,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned X_OFFSET   = 0,
  parameter int unsigned Y_OFFSET   = 0,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned CW         = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enable,
  output logic          pixel_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic [CW-1:0] PlayX,
  output logic [CW-1:0] PlayY,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int unsigned    DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]  X_OFF      = CW'(X_OFFSET);
  localparam logic [CW-1:0]  Y_OFF      = CW'(Y_OFFSET);
  localparam logic [CW-1:0]  PLAY_X_RST = X_OFF >> SCALE_LOG2;
  localparam logic [CW-1:0]  PLAY_Y_RST = Y_OFF >> SCALE_LOG2;
  localparam logic [CW-1:0]  V_ACT_C    = CW'(V_ACTIVE);

  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic             clear;
  logic             running;
  logic [DIV_W-1:0] div_cnt;
  logic [CW-1:0]    h_count, h_next, v_count, v_next;
  logic             h_wrap, h_sync_active, h_sync_level, h_visible;
  logic             v_wrap, v_sync_active, v_sync_level, v_visible;
  logic [CW-1:0]    play_x_sum, play_y_sum;

  assign clear = Reset | ~Enable;

  // running delays the divider by one Clk after release, so the first pixel
  // advance lands CLK_DIV Clks after the first running edge, for any CLK_DIV.
  always_ff @(posedge Clk) begin
    if (clear) begin
      running <= 1'b0;
      div_cnt <= '0;
    end else begin
      running <= 1'b1;
      if (running) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign pixel_ce = running & (div_cnt == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .Clk(Clk), .Reset(clear), .step(pixel_ce),
    .count(h_count), .next_count(h_next), .wrap(h_wrap),
    .sync_active(h_sync_active), .sync_level(h_sync_level), .visible(h_visible)
  );

  // The vertical axis steps only on a horizontal wrap, which keeps vs
  // line-aligned.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .Clk(Clk), .Reset(clear), .step(h_wrap),
    .count(v_count), .next_count(v_next), .wrap(v_wrap),
    .sync_active(v_sync_active), .sync_level(v_sync_level), .visible(v_visible)
  );

  assign DrawX      = h_count;
  assign DrawY      = v_count;
  // CW-bit sums wrap modulo 2^CW before the logical shift.
  assign play_x_sum = h_next + X_OFF;
  assign play_y_sum = v_next + Y_OFF;

  // NOTE: the clear branch spells out the idle values even though the
  // next-state decode would also produce them, so the reset state can be
  // read here without tracing the axis counters.
  always_ff @(posedge Clk) begin
    if (clear) begin
      hs           <= ~HS_POL;
      vs           <= ~VS_POL;
      blank        <= 1'b0;
      sync         <= 1'b1;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      PlayX        <= PLAY_X_RST;
      PlayY        <= PLAY_Y_RST;
    end else begin
      hs           <= h_sync_level;
      vs           <= v_sync_level;
      blank        <= h_visible & v_visible;
      sync         <= ~(h_sync_active | v_sync_active);
      line_start   <= h_wrap;
      frame_start  <= h_wrap & v_wrap;
      vblank_start <= h_wrap & (v_next == V_ACT_C);
      PlayX        <= play_x_sum >> SCALE_LOG2;
      PlayY        <= play_y_sum >> SCALE_LOG2;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances run side by side:
//   0: default 640x480 timing, CLK_DIV=2
//   1: defaults with X_OFFSET=100, SCALE_LOG2=1
//   2: tiny 8/1/2/1 x 4/1/1/1 raster, CLK_DIV=1, active-high syncs, offsets
//      chosen so PlayY wraps modulo 2^CW
// On every Clk edge the reference model derives each instance's outputs from
// the number of Clks since release (pixel index = clocks / CLK_DIV, then
// plain div/mod into x and y) and queues them; a monitor on the falling edge
// pops and compares.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NI   = 3;
  localparam int NCYC = 15000;

  typedef struct packed {
    logic   pixel_ce, hs, vs, blank, sync;
    coord_t x, y, px, py;
    logic   ls, fs, vbs;
  } obs_t;

  typedef struct {
    obs_t e;
    bit   play_care;
  } item_t;

  typedef struct packed {
    int unsigned div, ha, hfp, hsw, hbp, va, vfp, vsw, vbp, xo, yo, sc;
    bit          hpol, vpol;
  } cfg_t;

  localparam cfg_t CFG_A = '{div: 2, ha: 640, hfp: 16, hsw: 96, hbp: 48,
                             va: 480, vfp: 10, vsw: 2, vbp: 33,
                             xo: 0, yo: 0, sc: 0, hpol: 1'b0, vpol: 1'b0};
  localparam cfg_t CFG_B = '{div: 2, ha: 640, hfp: 16, hsw: 96, hbp: 48,
                             va: 480, vfp: 10, vsw: 2, vbp: 33,
                             xo: 100, yo: 0, sc: 1, hpol: 1'b0, vpol: 1'b0};
  localparam cfg_t CFG_C = '{div: 1, ha: 8, hfp: 1, hsw: 2, hbp: 1,
                             va: 4, vfp: 1, vsw: 1, vbp: 1,
                             xo: 3, yo: 1021, sc: 1, hpol: 1'b1, vpol: 1'b1};
  localparam cfg_t CFG[NI] = '{CFG_A, CFG_B, CFG_C};

  bit     Clk = 1'b0;
  logic   rst [NI];
  logic   en  [NI];
  logic   pce [NI], hs_o [NI], vs_o [NI], blank_o [NI], sync_o [NI];
  logic   ls_o [NI], fs_o [NI], vbs_o [NI];
  coord_t dx [NI], dy [NI], px [NI], py [NI];
  obs_t   act [NI];

  longint m [NI];
  item_t  q [NI][$];
  int     hold  [NI];
  int     phase [NI];
  int     n_checks = 0;
  int     n_fail   = 0;
  string  name [NI] = '{"default_640x480", "offset_scale", "small_pol"};

  always #5 Clk = ~Clk;

  vga_timing_gen u_dut_a (
    .Clk(Clk), .Reset(rst[0]), .Enable(en[0]),
    .pixel_ce(pce[0]), .hs(hs_o[0]), .vs(vs_o[0]), .blank(blank_o[0]), .sync(sync_o[0]),
    .DrawX(dx[0]), .DrawY(dy[0]), .PlayX(px[0]), .PlayY(py[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]), .vblank_start(vbs_o[0])
  );

  vga_timing_gen #(
    .X_OFFSET(CFG_B.xo), .Y_OFFSET(CFG_B.yo), .SCALE_LOG2(CFG_B.sc)
  ) u_dut_b (
    .Clk(Clk), .Reset(rst[1]), .Enable(en[1]),
    .pixel_ce(pce[1]), .hs(hs_o[1]), .vs(vs_o[1]), .blank(blank_o[1]), .sync(sync_o[1]),
    .DrawX(dx[1]), .DrawY(dy[1]), .PlayX(px[1]), .PlayY(py[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]), .vblank_start(vbs_o[1])
  );

  vga_timing_gen #(
    .CLK_DIV(CFG_C.div),
    .H_ACTIVE(CFG_C.ha), .H_FP(CFG_C.hfp), .H_SYNC(CFG_C.hsw), .H_BP(CFG_C.hbp),
    .V_ACTIVE(CFG_C.va), .V_FP(CFG_C.vfp), .V_SYNC(CFG_C.vsw), .V_BP(CFG_C.vbp),
    .HS_POL(CFG_C.hpol), .VS_POL(CFG_C.vpol),
    .X_OFFSET(CFG_C.xo), .Y_OFFSET(CFG_C.yo), .SCALE_LOG2(CFG_C.sc), .CW(10)
  ) u_dut_c (
    .Clk(Clk), .Reset(rst[2]), .Enable(en[2]),
    .pixel_ce(pce[2]), .hs(hs_o[2]), .vs(vs_o[2]), .blank(blank_o[2]), .sync(sync_o[2]),
    .DrawX(dx[2]), .DrawY(dy[2]), .PlayX(px[2]), .PlayY(py[2]),
    .line_start(ls_o[2]), .frame_start(fs_o[2]), .vblank_start(vbs_o[2])
  );

  for (genvar g = 0; g < NI; g++) begin : g_pack
    assign act[g] = {pce[g], hs_o[g], vs_o[g], blank_o[g], sync_o[g],
                     dx[g], dy[g], px[g], py[g], ls_o[g], fs_o[g], vbs_o[g]};
  end

  // Expected outputs after the edge that is m Clks past the release edge
  // (m < 0: held in reset).
  function automatic obs_t model(input cfg_t c, input longint m_in);
    obs_t   o;
    longint d, ht, vt, n, x, y, hs0, vs0, modv;
    bit     hsa, vsa, adv, run;
    d    = longint'(c.div);
    ht   = longint'(total(c.ha, c.hfp, c.hsw, c.hbp));
    vt   = longint'(total(c.va, c.vfp, c.vsw, c.vbp));
    modv = longint'(1) << $bits(coord_t);
    run  = (m_in >= 0);
    n    = run ? m_in / d : 0;
    x    = n % ht;
    y    = (n / ht) % vt;
    adv  = (m_in > 0) && (m_in % d == 0);
    hs0  = longint'(c.ha) + longint'(c.hfp);
    vs0  = longint'(c.va) + longint'(c.vfp);
    hsa  = run && (x >= hs0) && (x < hs0 + longint'(c.hsw));
    vsa  = run && (y >= vs0) && (y < vs0 + longint'(c.vsw));
    o.pixel_ce = run && ((m_in + 1) % d == 0);
    o.hs       = hsa ? c.hpol : !c.hpol;
    o.vs       = vsa ? c.vpol : !c.vpol;
    o.blank    = run && (x < longint'(c.ha)) && (y < longint'(c.va));
    o.sync     = !(hsa || vsa);
    o.x        = coord_t'(x);
    o.y        = coord_t'(y);
    o.px       = coord_t'(((x + longint'(c.xo)) % modv) >> c.sc);
    o.py       = coord_t'(((y + longint'(c.yo)) % modv) >> c.sc);
    o.ls       = adv && (x == 0);
    o.fs       = adv && (x == 0) && (y == 0);
    o.vbs      = adv && (x == 0) && (y == longint'(c.va));
    return o;
  endfunction

  task automatic check(input int inst, input obs_t a, input obs_t e, input bit play_care);
    obs_t mask;
    mask = '1;
    if (!play_care) begin
      mask.px = '0;
      mask.py = '0;
    end
    n_checks++;
    if (((a ^ e) & mask) !== '0) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s outputs at t=%0t: got %p, required %p (play checked=%0b)",
                 name[inst], $time, a, e, play_care);
    end
  endtask

  // Reference model and scoreboard producer.
  always @(posedge Clk) begin
    for (int i = 0; i < NI; i++) begin
      item_t it;
      if (rst[i] || !en[i]) m[i] = -1;
      else                  m[i] = (m[i] < 0) ? 0 : m[i] + 1;
      it.e         = model(CFG[i], m[i]);
      it.play_care = (m[i] < 0) || it.e.blank;
      q[i].push_back(it);
    end
  end

  // Monitor: the outputs of every instance are valid on every Clk.
  always @(negedge Clk) begin
    for (int i = 0; i < NI; i++) begin
      if (q[i].size() > 0) begin
        item_t it;
        it = q[i].pop_front();
        check(i, act[i], it.e, it.play_care);
      end
    end
  end

  // Random disruption: reset, Enable low, or both, for 1..max_len Clks.
  task automatic disrupt(input int i, input int max_len);
    int kind;
    kind    = int'($urandom_range(0, 2));
    rst[i]  = (kind != 1);
    en[i]   = (kind == 0);
    hold[i] = int'($urandom_range(1, max_len));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i]   = 1'b1;
      en[i]    = 1'b1;
      m[i]     = -1;
      hold[i]  = 0;
      phase[i] = 0;
    end
    repeat (3) @(negedge Clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge Clk);
      for (int i = 0; i < NI; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) begin
            rst[i] = 1'b0;
            en[i]  = 1'b1;
          end
        end else begin
          case (i)
            0: begin
              // Reset at DrawX=400 mid-line, then Enable low inside hs
              // (DrawX=700), then sparse random disruption.
              if (phase[0] == 0 && m[0] == 2 * (800 + 400)) begin
                rst[0] = 1'b1; hold[0] = 1; phase[0] = 1;
              end else if (phase[0] == 1 && m[0] == 2 * (800 + 700)) begin
                en[0] = 1'b0; hold[0] = 3; phase[0] = 2;
              end else if (phase[0] == 2 && $urandom_range(0, 2999) == 0) begin
                disrupt(0, 3);
              end
            end
            1: begin
              // Undisturbed long enough to reach DrawY=7.
              if (cyc > 12500 && $urandom_range(0, 999) == 0) disrupt(1, 3);
            end
            default: begin
              // Enable low for 3 Clks mid-frame, then frequent random hits.
              if (phase[2] == 0 && m[2] == 40) begin
                en[2] = 1'b0; hold[2] = 3; phase[2] = 1;
              end else if (phase[2] == 1 && m[2] > 200 && $urandom_range(0, 99) == 0) begin
                disrupt(2, 4);
              end
            end
          endcase
        end
      end
    end

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 vga_controller. It generates the pixel-rate enable, HS/VS, blank and sync signals, plus raw (DrawX, DrawY) and playfield (PlayX, PlayY) coordinates, for any resolution and porch set from a single system clock. It adds polarity control, a playfield offset, power-of-two pixel replication, per-line/per-frame event strobes and a run/hold enable. It sits between the board clock and game/color_mapper, replacing the VS-as-frame-clock practice with single-cycle strobes.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, 1 = hs active-high, 0 = active-low
VS_POL, 0, as HS_POL for vs
X_OFFSET, 0, added to DrawX before scaling
Y_OFFSET, 0, added to DrawY before scaling
SCALE_LOG2, 0, playfield pixel replication: right shift applied after the offset
CW, 10, coordinate width; H_TOTAL and V_TOTAL must be <= 2^CW (elaboration error otherwise)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high
Enable  in  1  1 = run; 0 = held in reset state
pixel_ce  out  1  one-Clk pulse per pixel period
hs  out  1  horizontal sync, polarity HS_POL
vs  out  1  vertical sync, polarity VS_POL
blank  out  1  active-low blank: 1 = visible pixel
sync  out  1  composite sync, active-low: 0 while hs or vs is asserted
DrawX  out  CW  raw horizontal count
DrawY  out  CW  raw vertical count
PlayX  out  CW  (DrawX + X_OFFSET) >> SCALE_LOG2
PlayY  out  CW  (DrawY + Y_OFFSET) >> SCALE_LOG2
line_start  out  1  one-Clk strobe when DrawX wraps to 0
frame_start  out  1  one-Clk strobe when (DrawX, DrawY) wraps to (0,0)
vblank_start  out  1  one-Clk strobe when DrawY advances V_ACTIVE-1 -> V_ACTIVE

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise.
- Divider: div_cnt counts 0..CLK_DIV-1. pixel_ce is asserted combinationally from the registered count when div_cnt == CLK_DIV-1. With CLK_DIV=1, pixel_ce is constantly 1 while running.
- Advance rules, all on a pixel_ce cycle:
  - DrawX increments; at H_TOTAL-1 it wraps to 0.
  - On a DrawX wrap, DrawY increments; at V_TOTAL-1 it wraps to 0.
- All outputs except pixel_ce are registered and change on the same Clk edge as the counters they describe (computed from next-state counts). There is zero skew between DrawX/DrawY and hs/vs/blank.
- hs asserted while H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC.
- vs asserted while V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC. vs is line-aligned and changes at the DrawX wrap edge.
- blank = 1 iff DrawX < H_ACTIVE and DrawY < V_ACTIVE, and the block is running.
- sync = ~(hs asserted | vs asserted), independent of HS_POL/VS_POL.
- Strobes are one Clk wide, coincident with the counter update edge:
  - line_start on every DrawX wrap.
  - frame_start on the (V_TOTAL-1, H_TOTAL-1) -> (0,0) transition.
  - vblank_start on the DrawY transition to V_ACTIVE.
- Play coordinates: the addition is modulo 2^CW and the shift is logical. PlayX/PlayY are registered with DrawX/DrawY. Their values are don't-care when blank = 0.
- Reset or Enable=0, applied on the next Clk:
  - div_cnt, DrawX, DrawY = 0.
  - PlayX = X_OFFSET >> SCALE_LOG2; PlayY = Y_OFFSET >> SCALE_LOG2.
  - hs = ~HS_POL, vs = ~VS_POL (inactive); sync = 1; blank = 0.
  - pixel_ce and all strobes = 0.
- Release: the first pixel_ce occurs CLK_DIV Clks after the first Clk with Reset=0 and Enable=1. The counter advance on that pulse moves DrawX from 0 to 1. No frame_start is generated on release; the first one occurs on the first wrap.
- Reset mid-line or mid-sync: immediate synchronous clear; no partial pulse is extended.
- Reset has priority over Enable.

Decomposition:
- Package vga_timing_pkg holds:
  - typedef coord_t (logic [CW-1:0] at default CW).
  - localparam presets MODE_640x480_60 (CLK_DIV=2) and MODE_800x600_72 (CLK_DIV=1 at 50 MHz), as porch/sync groups.
  - function total(active, fp, sync, bp).
- Sub-module vga_axis_counter is instantiated twice (horizontal, vertical). It takes params ACTIVE/FP/SYNC/BP/POL and inputs Clk, Reset, step. It outputs count, sync_active, visible and wrap, plus next_count for output alignment.

Test Plan:
- Defaults: pixel_ce every 2nd Clk; line = 1600 Clks; hs = 0 exactly while DrawX = 656..751 (96 pixels); line_start period 1600 Clks.
- Defaults, full frame: frame_start period 840000 Clks (800x525x2); vs = 0 exactly while DrawY = 490..491; vblank_start while DrawY goes 479 -> 480; sync = 0 whenever hs or vs is low.
- Blank edge: at DrawX 639 -> 640 (DrawY=100), blank falls on the same Clk edge; at DrawY 479 -> 480 it stays 0 for whole lines; it returns to 1 at (0,0).
- X_OFFSET=100, Y_OFFSET=0, SCALE_LOG2=1: DrawX=0 -> PlayX=50; DrawX=300 -> PlayX=200; DrawY=7 -> PlayY=3.
- Reset asserted at DrawX=400, DrawY=200: next Clk has DrawX=DrawY=0, hs=vs=1, sync=1, blank=0, no strobes. After release, first pixel_ce is 2 Clks later; no frame_start until the full frame completes.
- CLK_DIV=1, HS_POL=1, VS_POL=1, H=8/1/2/1, V=4/1/1/1:
  - hs=1 only at DrawX=9,10; DrawX wraps 11 -> 0 with line_start.
  - vs=1 only on DrawY=5; frame_start every 84 Clks.
  - Enable=0 for 3 Clks mid-frame clears as reset.
